// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl
// Converts a binary value to BCD with a sequential double-dabble, one bit per
// cycle. It then scans up to 8 seven-segment digits with leading-zero blanking
// and an overflow indication. Each digit slot is serialised as one 16-bit
// frame {dp, gfedcba, sel} into a 74HC595 chain, MSB first.
//
// Ports:
//   sys_clk      sole clock
//   reset_n      asynchronous active-low reset
//   en           display enable; 0 sends blank frames (16'hFFFF)
//   value        binary value to display (DATA_W bits)
//   value_valid  value is offered this cycle
//   value_ready  converter idle, a value will be accepted
//   overflow     latched value needs more than DIGITS decimal digits
//   sh_cp        595 shift clock
//   st_cp        595 storage/latch clock
//   ds           595 serial data
module seg_display_ctrl #(
    parameter int DATA_W   = 32,
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 50000,
    parameter int SCK_DIV  = 4,
    parameter int BLANK_LZ = 1
) (
    input  logic              sys_clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [DATA_W-1:0] value,
    input  logic              value_valid,
    output logic              value_ready,
    output logic              overflow,
    output logic              sh_cp,
    output logic              st_cp,
    output logic              ds
);
    localparam int BCD_W  = 4 * DIGITS;
    localparam int CNT_W  = $clog2(DATA_W + 1);
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SCK_W  = $clog2(SCK_DIV + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} conv_state_t;
    typedef enum logic [1:0] {SH_IDLE, SH_DATA, SH_LATCH_HI, SH_LATCH_LO} sh_state_t;

    // Add 3 to every nibble >= 5 before the shift (double-dabble correction).
    function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < DIGITS; i++) begin
            if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    // Active-low gfedcba; codes 10..15 cannot occur and map to blank.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // ---------------- converter ----------------
    conv_state_t      state, state_next;
    logic [CNT_W-1:0] shift_cnt;
    logic [DATA_W-1:0] bin_sr;
    logic [BCD_W-1:0] bcd, bcd_adj, disp_buf;
    logic             ovf;

    assign bcd_adj = dabble_adjust(bcd);

    always_comb begin
        state_next  = state;
        value_ready = 1'b0;
        case (state)
            IDLE: begin
                value_ready = 1'b1;
                if (value_valid) state_next = SHIFT;
            end
            SHIFT:   if (shift_cnt == CNT_W'(DATA_W - 1)) state_next = LATCH;
            LATCH:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            shift_cnt <= '0;
            ovf       <= 1'b0;
            disp_buf  <= '0;
            overflow  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (value_valid) begin
                    shift_cnt <= '0;
                    ovf       <= 1'b0;
                end
                SHIFT: begin
                    shift_cnt <= shift_cnt + 1'b1;
                    // A 1 leaving the top nibble means the value needs another digit.
                    if (bcd_adj[BCD_W-1]) ovf <= 1'b1;
                end
                LATCH: begin
                    disp_buf <= bcd;
                    overflow <= ovf;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (state == IDLE && value_valid) begin
            bin_sr <= value;
            bcd    <= '0;
        end else if (state == SHIFT) begin
            bcd    <= {bcd_adj[BCD_W-2:0], bin_sr[DATA_W-1]};
            bin_sr <= bin_sr << 1;
        end
    end

    // ---------------- scan and frame build ----------------
    logic [SCAN_W-1:0] scan_cnt;
    logic [2:0]        digit_idx;
    logic              pending, scan_tick, frame_start;
    logic [3:0]        cur_digit;
    logic              upper_nz;
    logic [6:0]        seg;
    logic [7:0]        sel;
    logic [15:0]       frame;
    sh_state_t         sh_state, sh_next;

    assign scan_tick   = (scan_cnt == SCAN_W'(SCAN_DIV - 1));
    assign frame_start = pending && (sh_state == SH_IDLE);

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
            pending   <= 1'b1;
        end else begin
            if (scan_tick) begin
                scan_cnt  <= '0;
                digit_idx <= (digit_idx == 3'(DIGITS - 1)) ? 3'd0 : digit_idx + 3'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            // Ticks during a busy frame collapse into one pending flag.
            pending <= scan_tick | (pending & ~frame_start);
        end
    end

    always_comb begin
        cur_digit = 4'd0;
        upper_nz  = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (3'(i) == digit_idx) cur_digit = disp_buf[4*i +: 4];
            if (i >= int'(digit_idx) && disp_buf[4*i +: 4] != 4'd0) upper_nz = 1'b1;
        end
        if (overflow)                                        seg = 7'b0111111;
        else if (BLANK_LZ != 0 && digit_idx != 3'd0 && !upper_nz) seg = 7'b1111111;
        else                                                 seg = seg7(cur_digit);
        sel            = 8'hFF;
        sel[digit_idx] = 1'b0;
        frame          = en ? {1'b1, seg, sel} : 16'hFFFF;
    end

    // ---------------- 595 shifter ----------------
    logic [SCK_W-1:0] sck_cnt;
    logic             sck_end;
    logic [3:0]       bit_cnt;
    logic [15:0]      frame_sr;

    assign sck_end = (sck_cnt == SCK_W'(SCK_DIV - 1));

    always_comb begin
        sh_next = sh_state;
        case (sh_state)
            SH_IDLE:     if (frame_start) sh_next = SH_DATA;
            SH_DATA:     if (sck_end && sh_cp && bit_cnt == 4'd15) sh_next = SH_LATCH_HI;
            SH_LATCH_HI: if (sck_end) sh_next = SH_LATCH_LO;
            SH_LATCH_LO: if (sck_end) sh_next = SH_IDLE;
            default:     sh_next = SH_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_state <= SH_IDLE;
            sck_cnt  <= '0;
            bit_cnt  <= '0;
            sh_cp    <= 1'b0;
            st_cp    <= 1'b0;
            ds       <= 1'b0;
        end else begin
            sh_state <= sh_next;
            sck_cnt  <= (sh_state == SH_IDLE || sck_end) ? '0 : sck_cnt + 1'b1;
            case (sh_state)
                SH_IDLE: if (frame_start) begin
                    ds      <= frame[15];
                    bit_cnt <= '0;
                    sh_cp   <= 1'b0;
                    st_cp   <= 1'b0;
                end
                SH_DATA: if (sck_end) begin
                    if (!sh_cp) begin
                        sh_cp <= 1'b1;
                    end else begin
                        // Falling edge: present the next bit, or start the latch pulse.
                        sh_cp <= 1'b0;
                        if (bit_cnt == 4'd15) begin
                            ds    <= 1'b0;
                            st_cp <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                            ds      <= frame_sr[14];
                        end
                    end
                end
                SH_LATCH_HI: if (sck_end) st_cp <= 1'b0;
                default: ;
            endcase
        end
    end

    // Frame is snapshotted at start so buffer/en changes never tear it.
    always_ff @(posedge sys_clk) begin
        if (frame_start) frame_sr <= frame;
        else if (sh_state == SH_DATA && sck_end && sh_cp) frame_sr <= {frame_sr[14:0], 1'b0};
    end
endmodule

// File: tb/tb_seg_display_ctrl.sv
module tb_seg_display_ctrl;
    logic        sys_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b1;
    logic [31:0] value = '0;
    logic        value_valid = 1'b0;
    logic        value_ready, overflow, sh_cp, st_cp, ds;

    seg_display_ctrl #(.DATA_W(32), .DIGITS(8), .SCAN_DIV(100), .SCK_DIV(2), .BLANK_LZ(1)) dut (
        .sys_clk(sys_clk), .reset_n(reset_n), .en(en), .value(value), .value_valid(value_valid),
        .value_ready(value_ready), .overflow(overflow), .sh_cp(sh_cp), .st_cp(st_cp), .ds(ds)
    );

    always #5 sys_clk = ~sys_clk;

    int passed = 0;
    int total  = 0;

    localparam logic [6:0] SEG [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    // Frame monitor: shifts ds in on each sh_cp rise, closes a frame on st_cp fall.
    logic [15:0] sr = '0, last_frame = '0;
    logic        prev_sh = 1'b0, prev_st = 1'b0;
    int nbits = 0, frame_cnt = 0, st_w = 0, last_st_w = 0, cyc = 0, t_rise = 0, last_span = 0;

    always @(negedge sys_clk) begin
        cyc++;
        if (!reset_n) begin
            nbits = 0; st_w = 0; prev_sh = 1'b0; prev_st = 1'b0;
        end else begin
            if (sh_cp && !prev_sh) begin
                if (nbits == 0) t_rise = cyc;
                sr = {sr[14:0], ds};
                nbits++;
            end
            if (st_cp) st_w++;
            if (!st_cp && prev_st) begin
                last_frame = sr;
                last_st_w  = st_w;
                last_span  = cyc - t_rise;
                st_w = 0; nbits = 0;
                frame_cnt++;
            end
            prev_sh = sh_cp;
            prev_st = st_cp;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [15:0] model_frame(input longint v, input int d);
        logic [6:0] s;
        logic [7:0] sl;
        longint p, q;
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        q = v / p;
        if (v >= 100000000)     s = 7'b0111111;
        else if (d > 0 && q == 0) s = 7'b1111111;
        else                    s = SEG[int'(q % 10)];
        sl = 8'hFF;
        sl[d] = 1'b0;
        return {1'b1, s, sl};
    endfunction

    task automatic wait_frame(output logic [15:0] f);
        int start;
        bit got;
        start = frame_cnt;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(posedge sys_clk);
            if (frame_cnt != start) got = 1'b1;
        end
        if (!got) begin
            total++;
            $display("FAIL frame_timeout: no frame within 400 cycles");
            f = 'x;
        end else f = last_frame;
    endtask

    task automatic find_digit(input int d, output logic [15:0] f);
        logic [7:0] want;
        bit found;
        want = 8'hFF;
        want[d] = 1'b0;
        found = 1'b0;
        f = 'x;
        for (int i = 0; i < 10 && !found; i++) begin
            wait_frame(f);
            if (f[7:0] === want) found = 1'b1;
        end
        if (!found) begin
            total++;
            $display("FAIL digit_search: digit %0d frame never seen, last %h", d, f);
        end
    endtask

    task automatic wait_ready();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge sys_clk);
            if (value_ready) got = 1'b1;
        end
        if (!got) begin
            total++;
            $display("FAIL ready_timeout: value_ready stayed low");
        end
    endtask

    task automatic load_value(input logic [31:0] v);
        logic [15:0] dummy;
        wait_ready();
        @(negedge sys_clk);
        value = v;
        value_valid = 1'b1;
        @(negedge sys_clk);
        value_valid = 1'b0;
        wait_ready();
        wait_frame(dummy);   // discard a frame that may have started before the latch
    endtask

    task automatic wait_nbits(input int n);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge sys_clk);
            #1;
            if (nbits == n) got = 1'b1;
        end
        if (!got) begin
            total++;
            $display("FAIL nbits_timeout: bit %0d of a frame never reached", n);
        end
    endtask

    typedef struct {
        logic [31:0] val;
        int          dig;
        logic [15:0] frame;
        logic        ovf;
    } vec_t;

    vec_t vecs [22];

    initial begin
        logic [15:0] f;
        logic [31:0] loaded;
        bit          have_loaded;
        int          first_hi, d;

        vecs[0]  = '{32'd12345678,  0, 16'h80FE, 1'b0};
        vecs[1]  = '{32'd12345678,  7, 16'hF97F, 1'b0};
        vecs[2]  = '{32'd12345678,  3, 16'h92F7, 1'b0};
        vecs[3]  = '{32'd12345678,  5, 16'hB0DF, 1'b0};
        vecs[4]  = '{32'd100000000, 3, 16'hBFF7, 1'b1};
        vecs[5]  = '{32'd100000000, 0, 16'hBFFE, 1'b1};
        vecs[6]  = '{32'd7,         0, 16'hF8FE, 1'b0};
        vecs[7]  = '{32'd7,         1, 16'hFFFD, 1'b0};
        vecs[8]  = '{32'd7,         7, 16'hFF7F, 1'b0};
        vecs[9]  = '{32'd1000,      0, 16'hC0FE, 1'b0};
        vecs[10] = '{32'd1000,      2, 16'hC0FB, 1'b0};
        vecs[11] = '{32'd1000,      3, 16'hF9F7, 1'b0};
        vecs[12] = '{32'd1000,      4, 16'hFFEF, 1'b0};
        vecs[13] = '{32'd60,        0, 16'hC0FE, 1'b0};
        vecs[14] = '{32'd60,        1, 16'h82FD, 1'b0};
        vecs[15] = '{32'd60,        2, 16'hFFFB, 1'b0};
        vecs[16] = '{32'd0,         0, 16'hC0FE, 1'b0};
        vecs[17] = '{32'd0,         1, 16'hFFFD, 1'b0};
        vecs[18] = '{32'd99999999,  7, 16'h907F, 1'b0};
        vecs[19] = '{32'd99999999,  0, 16'h90FE, 1'b0};
        vecs[20] = '{32'hFFFFFFFF,  7, 16'hBF7F, 1'b1};
        vecs[21] = '{32'hFFFFFFFF,  2, 16'hBFFB, 1'b1};

        // Reset state
        repeat (3) @(negedge sys_clk);
        check("rst_sh_cp", 32'(sh_cp), 32'd0);
        check("rst_st_cp", 32'(st_cp), 32'd0);
        check("rst_ds", 32'(ds), 32'd0);
        check("rst_ready", 32'(value_ready), 32'd1);
        check("rst_overflow", 32'(overflow), 32'd0);

        // First frame starts on the first edge after release
        reset_n = 1'b1;
        @(negedge sys_clk);
        check("first_ds_b15", 32'(ds), 32'd1);
        check("first_sh_low", 32'(sh_cp), 32'd0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        check("first_sh_rise", 32'(sh_cp), 32'd1);
        wait_frame(f);
        check("boot_digit0", 32'(f), 32'h0000C0FE);
        check("st_cp_width", 32'(last_st_w), 32'd2);
        check("rise_to_latch_end", 32'(last_span), 32'd64);
        wait_frame(f);
        check("boot_digit1", 32'(f), 32'h0000FFFD);

        // Handshake latency
        wait_ready();
        @(negedge sys_clk);
        value = 32'd12345678;
        value_valid = 1'b1;
        @(negedge sys_clk);
        value_valid = 1'b0;
        first_hi = 0;
        for (int k = 1; k <= 40; k++) begin
            if (value_ready && first_hi == 0) first_hi = k;
            @(negedge sys_clk);
        end
        check("ready_return_cycle", 32'(first_hi), 32'd34);

        // Table-driven display vectors
        have_loaded = 1'b0;
        loaded = '0;
        for (int i = 0; i < 22; i++) begin
            if (!have_loaded || loaded !== vecs[i].val) begin
                load_value(vecs[i].val);
                loaded = vecs[i].val;
                have_loaded = 1'b1;
            end
            find_digit(vecs[i].dig, f);
            check($sformatf("vec%0d_frame", i), 32'(f), 32'(vecs[i].frame));
            check($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
        end

        // value_valid during a conversion is ignored
        wait_ready();
        @(negedge sys_clk);
        value = 32'd42;
        value_valid = 1'b1;
        @(negedge sys_clk);
        value_valid = 1'b0;
        repeat (9) @(negedge sys_clk);
        check("busy_mid_conv", 32'(value_ready), 32'd0);
        value = 32'd5;
        value_valid = 1'b1;
        @(negedge sys_clk);
        value_valid = 1'b0;
        wait_ready();
        wait_frame(f);
        check("ign_overflow", 32'(overflow), 32'd0);
        find_digit(0, f);
        check("ign_digit0", 32'(f), 32'h0000A4FE);
        find_digit(1, f);
        check("ign_digit1", 32'(f), 32'h000099FD);
        find_digit(2, f);
        check("ign_digit2", 32'(f), 32'h0000FFFB);

        // Display enable
        @(negedge sys_clk);
        en = 1'b0;
        wait_frame(f);
        wait_frame(f);
        check("en0_frame_a", 32'(f), 32'h0000FFFF);
        wait_frame(f);
        check("en0_frame_b", 32'(f), 32'h0000FFFF);
        wait_nbits(4);
        en = 1'b1;
        wait_frame(f);
        check("en1_current_frame", 32'(f), 32'h0000FFFF);
        wait_frame(f);
        d = -1;
        for (int k = 0; k < 8; k++) if (f[7:0] == ~(8'h01 << k)) d = k;
        if (d < 0) begin
            total++;
            $display("FAIL en1_next_sel: got %h expected a one-hot-low select", f);
        end else begin
            check("en1_next_frame", 32'(f), 32'(model_frame(42, d)));
        end

        // Asynchronous reset mid-frame (bit b7 high phase) and mid-conversion
        load_value(32'd100000000);
        wait_nbits(5);
        value = 32'd555;
        value_valid = 1'b1;
        @(negedge sys_clk);
        value_valid = 1'b0;
        wait_nbits(9);
        check("pre_rst_busy", 32'(value_ready), 32'd0);
        check("pre_rst_sh_high", 32'(sh_cp), 32'd1);
        check("pre_rst_overflow", 32'(overflow), 32'd1);
        reset_n = 1'b0;
        #1;
        check("arst_sh_cp", 32'(sh_cp), 32'd0);
        check("arst_st_cp", 32'(st_cp), 32'd0);
        check("arst_ds", 32'(ds), 32'd0);
        check("arst_ready", 32'(value_ready), 32'd1);
        check("arst_overflow", 32'(overflow), 32'd0);
        repeat (3) @(negedge sys_clk);
        reset_n = 1'b1;
        wait_frame(f);
        check("post_rst_digit0", 32'(f), 32'h0000C0FE);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
